// File: rtl/tetris_board.sv
// tetris_board: flip-flop playfield for the Tetris game. Holds a COLS x ROWS
// grid of cell kinds and serves combinational reads to the display and to the
// collision checker. It accepts single-cell writes and a whole-board clear.
// A line-clear sweep walks from the bottom row up, removes full rows and lets
// the rows above fall by one.
module tetris_board #(
    parameter int COLS   = 10,
    parameter int ROWS   = 20,
    parameter int KIND_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        rd_x,
    input  logic [4:0]        rd_y,
    output logic [KIND_W-1:0] rd_kind,
    input  logic [4:0]        q_x,
    input  logic [4:0]        q_y,
    output logic              q_occ,
    input  logic              wr_en,
    input  logic [4:0]        wr_x,
    input  logic [4:0]        wr_y,
    input  logic [KIND_W-1:0] wr_kind,
    input  logic              new_game,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [4:0]        lines_cleared
);

    localparam int         XW       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int         YW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [4:0] COLS_C   = 5'(COLS);
    localparam logic [4:0] ROWS_C   = 5'(ROWS);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [KIND_W-1:0] grid [ROWS][COLS];
    logic [4:0]        row_ptr;
    logic [4:0]        count;
    logic              row_full;

    // Decoded per-cycle actions of the controller.
    logic start_scan, wipe, write_cell, shift_row, step_up, finish;

    logic rd_in_range, q_in_range, wr_in_range;

    assign rd_in_range = (rd_x < COLS_C) && (rd_y < ROWS_C);
    assign q_in_range  = (q_x < COLS_C) && (q_y < ROWS_C);
    assign wr_in_range = (wr_x < COLS_C) && (wr_y < ROWS_C);

    // Display and collision reads: out-of-range reads as empty for the display
    // and as solid for collisions, so the walls and floor block movement.
    always_comb begin
        rd_kind = '0;
        q_occ   = 1'b1;
        if (rd_in_range) begin
            rd_kind = grid[rd_y[YW-1:0]][rd_x[XW-1:0]];
        end
        if (q_in_range) begin
            q_occ = (grid[q_y[YW-1:0]][q_x[XW-1:0]] != '0);
        end
    end

    // A row is full when none of its cells is empty.
    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (grid[row_ptr[YW-1:0]][c] == '0) begin
                row_full = 1'b0;
            end
        end
    end

    // State register for the sweep controller.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples pre-edge values, whatever the block order.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and action decode; clear_start outranks new_game, and
    // new_game drops a simultaneous write.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        clear_busy = 1'b0;
        clear_done = 1'b0;
        start_scan = 1'b0;
        wipe       = 1'b0;
        write_cell = 1'b0;
        shift_row  = 1'b0;
        step_up    = 1'b0;
        finish     = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    start_scan = 1'b1;
                    state_d    = SCAN;
                end else if (new_game) begin
                    wipe = 1'b1;
                end
                write_cell = wr_en && wr_in_range && !wipe;
            end
            SCAN: begin
                clear_busy = 1'b1;
                if (row_full) begin
                    shift_row = 1'b1;
                end else if (row_ptr != '0) begin
                    step_up = 1'b1;
                end else begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                clear_busy = 1'b1;
                clear_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Playfield cells: wipe, gravity shift of a removed row, or a single write.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the grid is plain flip-flops rather than a RAM, so clearing it
        // in the reset branch is legal and gives the display a blank board.
        if (reset) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    grid[r][c] <= '0;
                end
            end
        end else if (wipe) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    grid[r][c] <= '0;
                end
            end
        end else if (shift_row) begin
            for (int r = 1; r < ROWS; r++) begin
                if (5'(r) <= row_ptr) begin
                    for (int c = 0; c < COLS; c++) begin
                        grid[r][c] <= grid[r-1][c];
                    end
                end
            end
            for (int c = 0; c < COLS; c++) begin
                grid[0][c] <= '0;
            end
        end else if (write_cell) begin
            grid[wr_y[YW-1:0]][wr_x[XW-1:0]] <= wr_kind;
        end
    end

    // Sweep row pointer, removed-row count and the reported result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_ptr       <= '0;
            count         <= '0;
            lines_cleared <= '0;
        end else begin
            if (start_scan) begin
                row_ptr       <= LAST_ROW;
                count         <= '0;
                lines_cleared <= '0;
            end else if (wipe) begin
                lines_cleared <= '0;
            end
            if (shift_row && (count != ROWS_C)) begin
                count <= count + 5'd1;
            end
            if (step_up) begin
                row_ptr <= row_ptr - 5'd1;
            end
            if (finish) begin
                lines_cleared <= count;
            end
        end
    end

endmodule

// File: tb/tb_tetris_board.sv
// tb_tetris_board: directed and randomized stimulus against a row-compaction
// reference model. Each sweep pushes its expected result into a scoreboard
// queue; a monitor pops and compares whenever clear_done is presented.
module tb_tetris_board;

    localparam int COLS   = 10;
    localparam int ROWS   = 20;
    localparam int KIND_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [4:0]        rd_x = '0, rd_y = '0, q_x = '0, q_y = '0;
    logic [KIND_W-1:0] rd_kind;
    logic              q_occ;
    logic              wr_en = 1'b0;
    logic [4:0]        wr_x = '0, wr_y = '0;
    logic [KIND_W-1:0] wr_kind = '0;
    logic              new_game = 1'b0;
    logic              clear_start = 1'b0;
    logic              clear_busy, clear_done;
    logic [4:0]        lines_cleared;

    typedef struct {
        int lines;
        int busy;
    } exp_t;

    exp_t sb[$];
    int   model [ROWS][COLS];
    int   vectors = 0;
    int   miscompares = 0;

    tetris_board #(.COLS(COLS), .ROWS(ROWS), .KIND_W(KIND_W)) dut (
        .clk(clk), .reset(reset),
        .rd_x(rd_x), .rd_y(rd_y), .rd_kind(rd_kind),
        .q_x(q_x), .q_y(q_y), .q_occ(q_occ),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_kind(wr_kind),
        .new_game(new_game), .clear_start(clear_start),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .lines_cleared(lines_cleared)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global timeout: run did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_clear();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) model[y][x] = 0;
    endfunction

    function automatic void model_write(input int x, input int y, input int k);
        if (x < COLS && y < ROWS) model[y][x] = k;
    endfunction

    // Remove every full row and stack the survivors at the bottom in order.
    function automatic int model_sweep();
        int tmp [ROWS][COLS];
        int n = 0;
        int dst = ROWS - 1;
        bit full;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) tmp[y][x] = 0;
        for (int y = ROWS - 1; y >= 0; y--) begin
            full = 1'b1;
            for (int x = 0; x < COLS; x++) if (model[y][x] == 0) full = 1'b0;
            if (full) n++;
            else begin
                for (int x = 0; x < COLS; x++) tmp[dst][x] = model[y][x];
                dst--;
            end
        end
        model = tmp;
        return n;
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic write_cell(input int x, input int y, input int k);
        @(negedge clk);
        wr_x = 5'(x); wr_y = 5'(y); wr_kind = KIND_W'(k); wr_en = 1'b1;
        model_write(x, y, k);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_new_game(input bit with_wr, input int x, input int y, input int k);
        @(negedge clk);
        new_game = 1'b1;
        if (with_wr) begin
            wr_x = 5'(x); wr_y = 5'(y); wr_kind = KIND_W'(k); wr_en = 1'b1;
        end
        model_clear();
        @(negedge clk);
        new_game = 1'b0; wr_en = 1'b0;
    endtask

    task automatic do_sweep(input bit with_wr, input int x, input int y, input int k,
                            input bit with_ng);
        int n;
        @(negedge clk);
        clear_start = 1'b1;
        new_game    = with_ng;
        if (with_wr) begin
            wr_x = 5'(x); wr_y = 5'(y); wr_kind = KIND_W'(k); wr_en = 1'b1;
            model_write(x, y, k);
        end
        n = model_sweep();
        sb.push_back('{n, ROWS + n + 1});
        @(negedge clk);
        clear_start = 1'b0; new_game = 1'b0; wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        @(negedge clk);
        while (clear_busy && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " sweep ended"}, int'(clear_busy), 0);
        check({name, " scoreboard drained"}, sb.size(), 0);
    endtask

    task automatic check_point(input string name, input int x, input int y,
                               input int exp_kind, input int exp_occ);
        rd_x = 5'(x); rd_y = 5'(y); q_x = 5'(x); q_y = 5'(y);
        #2;
        if (exp_kind >= 0) check($sformatf("%s rd_kind(%0d,%0d)", name, x, y), int'(rd_kind), exp_kind);
        if (exp_occ >= 0)  check($sformatf("%s q_occ(%0d,%0d)", name, x, y), int'(q_occ), exp_occ);
    endtask

    task automatic check_board(input string name);
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                check_point(name, x, y, model[y][x], int'(model[y][x] != 0));
    endtask

    task automatic fill_row(input int y, input int k);
        for (int x = 0; x < COLS; x++) write_cell(x, y, k);
    endtask

    // ---------------- monitor ----------------
    initial begin
        int   busy_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt = 0;
            end else begin
                if (clear_busy) busy_cnt++;
                if (clear_done) begin
                    check("clear_done has a pending expectation", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("lines_cleared at clear_done", int'(lines_cleared), e.lines);
                        check("clear_busy cycle count", busy_cnt, e.busy);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int hold;
        model_clear();

        // Power-on reset.
        reset = 1'b1;
        #12;
        check("reset clear_busy", int'(clear_busy), 0);
        check("reset clear_done", int'(clear_done), 0);
        check("reset lines_cleared", int'(lines_cleared), 0);
        check_board("reset");
        @(negedge clk);
        reset = 1'b0;

        // Read/write and out-of-range coordinates.
        write_cell(3, 7, 5);
        write_cell(12, 4, 2);
        check_point("rw", 3, 7, 5, 1);
        check_point("rw", 12, 4, 0, 1);
        check_point("rw", 0, 20, 0, 1);
        check_point("rw", 4, 7, 0, 0);
        check_point("rw", 31, 31, 0, 1);
        check_board("rw board");

        // new_game wins over a simultaneous write.
        do_new_game(1'b1, 1, 1, 6);
        check_board("new_game with write");

        // Empty sweep.
        do_sweep(1'b0, 0, 0, 0, 1'b0);
        wait_idle("empty");
        check("empty lines_cleared held", int'(lines_cleared), 0);

        // Single clear with gravity.
        fill_row(19, 1);
        write_cell(2, 18, 3);
        do_sweep(1'b0, 0, 0, 0, 1'b0);
        wait_idle("single");
        check_point("single", 2, 19, 3, 1);
        check_board("single board");
        check("single lines_cleared held", int'(lines_cleared), 1);

        // Non-contiguous tetris.
        do_new_game(1'b0, 0, 0, 0);
        fill_row(19, 2); fill_row(18, 3); fill_row(16, 4); fill_row(15, 5);
        write_cell(0, 17, 4);
        write_cell(9, 14, 6);
        do_sweep(1'b0, 0, 0, 0, 1'b0);
        wait_idle("tetris");
        check_point("tetris", 0, 19, 4, 1);
        check_point("tetris", 9, 18, 6, 1);
        check_board("tetris board");
        check("tetris lines_cleared held", int'(lines_cleared), 4);

        // Inputs ignored while busy; only one clear_done.
        do_sweep(1'b0, 0, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        wr_x = 5'd0; wr_y = 5'd0; wr_kind = 4'd7; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0; clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        wait_idle("busy-ignore");
        repeat (30) @(negedge clk);
        check("busy-ignore no second sweep", int'(clear_busy), 0);
        check("busy-ignore no extra done", sb.size(), 0);
        check_point("busy-ignore", 0, 0, 0, 0);
        check_board("busy-ignore board");

        // Write in the clear_start cycle completes a row; new_game is outranked.
        for (int x = 1; x < COLS; x++) write_cell(x, 10, 3);
        do_sweep(1'b1, 0, 10, 2, 1'b1);
        wait_idle("start+write");
        check_board("start+write board");
        do_new_game(1'b0, 0, 0, 0);
        check("new_game zeroes lines_cleared", int'(lines_cleared), 0);

        // Reset in the middle of a sweep.
        fill_row(19, 7);
        do_sweep(1'b0, 0, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        sb.delete();
        model_clear();
        #1;
        check("mid-sweep reset clear_busy", int'(clear_busy), 0);
        check("mid-sweep reset clear_done", int'(clear_done), 0);
        check("mid-sweep reset lines_cleared", int'(lines_cleared), 0);
        check_board("mid-sweep reset");
        @(negedge clk);
        reset = 1'b0;

        // Randomized boards.
        for (int round = 0; round < 6; round++) begin
            int mode, hole, k;
            do_new_game(1'b0, 0, 0, 0);
            for (int y = 0; y < ROWS; y++) begin
                mode = $urandom_range(0, 2);
                hole = $urandom_range(0, COLS - 1);
                for (int x = 0; x < COLS; x++) begin
                    if (mode == 0) k = $urandom_range(1, 7);
                    else if (x == hole) k = 0;
                    else k = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
                    if (k != 0) write_cell(x, y, k);
                end
            end
            write_cell($urandom_range(COLS, 31), $urandom_range(0, 31), 5);
            do_sweep(1'b0, 0, 0, 0, 1'b0);
            wait_idle($sformatf("random%0d", round));
            check_board($sformatf("random%0d board", round));
        end

        repeat (3) @(negedge clk);
        hold = miscompares;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, hold);
        $finish;
    end

endmodule
